ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Pipeline stage directly downstream of the 8-bit ALU. It captures the ALU result and carry-out into the EX/MEM pipeline register, along with destination and write-back control. It maintains the architectural Z/N/C flag register, whose C bit drives the ALU `carryin` on the next instruction. It also honours stall and flush from the hazard unit, and optionally exposes a forwarding path back to the operand muxes.

## Interface
- `DATA_W`, 8, ALU data width
- `REG_ADDR_W`, 3, register-file address width (8 registers)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX slot holds a real instruction
- `ex_result`  in  DATA_W  ALU `result`
- `ex_carryout`  in  1  ALU `carryout`
- `ex_ctrl`  in  6  ALU `control_sig` of the EX instruction; bit 3 = 0 means arithmetic (adder) path
- `ex_flags_en`  in  1  instruction updates flags
- `ex_rd`  in  REG_ADDR_W  destination register
- `ex_wb_en`, `ex_mem_rd`, `ex_mem_wr`  in  1 each  write-back and memory controls
- `stall`  in  1  hold EX/MEM contents; EX instruction not consumed
- `flush`  in  1  kill the EX instruction
- `mem_valid`  out  1  EX/MEM slot valid
- `mem_result`  out  DATA_W  registered result
- `mem_rd`  out  REG_ADDR_W  registered destination
- `mem_wb_en`, `mem_mem_rd`, `mem_mem_wr`  out  1 each  registered controls, gated by `mem_valid`
- `flag_z`, `flag_n`, `flag_c`  out  1 each  architectural flags; `flag_c` connects to ALU `carryin`
- `fwd_valid`  out  1  forwarding data valid
- `fwd_rd`  out  REG_ADDR_W  forwarding destination
- `fwd_data`  out  DATA_W  forwarding value

## Operation
- An accept happens when `ex_valid & ~stall & ~flush`.
- On accept, the EX/MEM register loads:
  - `mem_result <= ex_result`
  - `mem_rd <= ex_rd`
  - controls from their EX inputs
  - `mem_valid <= 1`
- `flush` (priority over `stall`): `mem_valid <= 0`; all `mem_*` controls <= 0; `mem_result` and `mem_rd` hold; flags unchanged.
- `stall` without `flush`: every EX/MEM field and every flag holds.
- `ex_valid = 0`, no stall, no flush: bubble, `mem_valid <= 0`, controls <= 0.
- Flag update, only on accept with `ex_flags_en = 1`:
  - Z <= (`ex_result` == 0)
  - N <= `ex_result[DATA_W-1]`
  - C <= `ex_carryout` only when `ex_ctrl[3] == 0`; on logic ops (`ex_ctrl[3] == 1`) C holds.
- Flush and stall never update flags.
- Write-back controls are never asserted while `mem_valid = 0`.

## Timing
- EX→MEM latency: 1 cycle. Flag latency: 1 cycle.
- An instruction accepted in cycle t sees flags written by the instruction accepted in cycle t-1. Back-to-back add-with-carry chains therefore need no stall.
- Reset (asynchronous assert, synchronous release) forces:
  - `mem_valid`, `mem_wb_en`, `mem_mem_rd`, `mem_mem_wr` = 0
  - `mem_result` = 0, `mem_rd` = 0
  - `flag_z` = 1, `flag_n` = 0, `flag_c` = 0
  - `fwd_*` = 0
- Reset mid-stall or mid-flush: reset wins; the first post-reset edge behaves as a normal cycle.
- Forwarding outputs are combinational from EX/MEM registers, with no added latency:
  - `fwd_valid = mem_valid & mem_wb_en & ~mem_mem_rd`
  - `fwd_rd = mem_rd`
  - `fwd_data = mem_result`
- Load results are never forwarded from this stage.

## Configuration
- `EX_MEM_FWD_EN` defined: forwarding logic is compiled in as described above.
- Undefined: `fwd_valid`, `fwd_rd` and `fwd_data` are tied to 0. The ports remain so that integration does not change, and the hazard unit must then stall on RAW dependencies.

## Structure
- The shared processor definitions package/header holds:
  - `DATA_W` and `REG_ADDR_W` defaults
  - flag bit indices (Z = 2, N = 1, C = 0)
  - the ALU control-bit index constant for the arithmetic/logic select (bit 3)
  - the flag reset value 3'b100
- One sub-module, `flag_reg`: a 3-bit flag register with update-enable, carry-update mask and asynchronous active-low reset.
- The EX/MEM register and the forwarding logic stay in the top level.

## Test plan
- Reset: hold `rst_n = 0` with random inputs -> `mem_valid = 0`, flags Z/N/C = 1/0/0, `fwd_valid = 0`. Release `rst_n` -> the first accepted instruction appears 1 cycle later.
- Arithmetic flags: accept `ex_result = 8'h00`, `ex_carryout = 1`, `ex_ctrl = 6'b000000`, `flags_en = 1` -> next cycle Z = 1, N = 0, C = 1, `mem_result = 8'h00`.
- Logic op preserves C: with C = 1, accept `ex_result = 8'h80`, `ex_ctrl[3] = 1`, `ex_carryout = 0` -> Z = 0, N = 1, C stays 1.
- Stall vs flush: stall for 3 cycles -> `mem_result` and flags frozen. Assert `stall` and `flush` together with `ex_result = 8'h55` -> `mem_valid = 0`, flags unchanged.
- Forwarding (`EX_MEM_FWD_EN`): accept `rd = 3`, `wb_en = 1`, result `8'hA7` -> `fwd_valid = 1`, `fwd_rd = 3`, `fwd_data = 8'hA7`. Same instruction with `mem_rd = 1` -> `fwd_valid = 0`. With the macro undefined -> all `fwd_*` = 0.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared processor definitions for the EX/MEM stage and flag register.
// Widths, flag bit positions, ALU control select bit and flag reset value.
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int REG_ADDR_W_DEF = 3;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    // ALU control bit choosing logic (1) versus adder (0) path
    localparam int CTRL_LOGIC_BIT = 3;

    localparam logic [2:0] FLAG_RST = 3'b100;

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural Z/N/C flag register with update enable and carry mask.
// Asynchronous active-low reset to FLAG_RST.
module flag_reg
    import ex_mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    input  logic       c_update,
    input  logic [2:0] next,
    output logic [2:0] flags
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= FLAG_RST;
        end else if (update) begin
            flags[FLAG_Z] <= next[FLAG_Z];
            flags[FLAG_N] <= next[FLAG_N];
            if (c_update) begin
                flags[FLAG_C] <= next[FLAG_C];
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, flag update and optional forwarding path.
// Forwarding is compiled in only when EX_MEM_FWD_EN is defined.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  ex_carryout,
    input  logic [5:0]            ex_ctrl,
    input  logic                  ex_flags_en,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_rd,
    input  logic                  ex_mem_wr,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_result,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_wb_en,
    output logic                  mem_mem_rd,
    output logic                  mem_mem_wr,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
);

    logic       accept;
    logic [2:0] flag_next;
    logic [2:0] flags;
    logic       ctrl_unused;

    assign accept = ex_valid & ~stall & ~flush;

    // Only the arithmetic/logic select bit matters at this stage
    assign ctrl_unused = ^{ex_ctrl[5:CTRL_LOGIC_BIT+1],
                           ex_ctrl[CTRL_LOGIC_BIT-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid  <= 1'b0;
            mem_result <= '0;
            mem_rd     <= '0;
            mem_wb_en  <= 1'b0;
            mem_mem_rd <= 1'b0;
            mem_mem_wr <= 1'b0;
        end else if (flush || (!stall && !ex_valid)) begin
            mem_valid  <= 1'b0;
            mem_wb_en  <= 1'b0;
            mem_mem_rd <= 1'b0;
            mem_mem_wr <= 1'b0;
        end else if (accept) begin
            mem_valid  <= 1'b1;
            mem_result <= ex_result;
            mem_rd     <= ex_rd;
            mem_wb_en  <= ex_wb_en;
            mem_mem_rd <= ex_mem_rd;
            mem_mem_wr <= ex_mem_wr;
        end
    end

    always_comb begin
        flag_next         = '0;
        flag_next[FLAG_Z] = (ex_result == '0);
        flag_next[FLAG_N] = ex_result[DATA_W-1];
        flag_next[FLAG_C] = ex_carryout;
    end

    flag_reg u_flag_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .update   (accept & ex_flags_en),
        .c_update (~ex_ctrl[CTRL_LOGIC_BIT]),
        .next     (flag_next),
        .flags    (flags)
    );

    assign flag_z = flags[FLAG_Z];
    assign flag_n = flags[FLAG_N];
    assign flag_c = flags[FLAG_C];

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their data only exists after the MEM stage
    assign fwd_valid = mem_valid & mem_wb_en & ~mem_mem_rd;
    assign fwd_rd    = mem_rd;
    assign fwd_data  = mem_result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
// Expected forwarding values follow EX_MEM_FWD_EN at compile time.
module tb_ex_mem_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic [7:0] ex_result;
    logic       ex_carryout;
    logic [5:0] ex_ctrl;
    logic       ex_flags_en;
    logic [2:0] ex_rd;
    logic       ex_wb_en, ex_mem_rd, ex_mem_wr;
    logic       stall, flush;
    logic       mem_valid;
    logic [7:0] mem_result;
    logic [2:0] mem_rd;
    logic       mem_wb_en, mem_mem_rd, mem_mem_wr;
    logic       flag_z, flag_n, flag_c;
    logic       fwd_valid;
    logic [2:0] fwd_rd;
    logic [7:0] fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_result   (ex_result),
        .ex_carryout (ex_carryout),
        .ex_ctrl     (ex_ctrl),
        .ex_flags_en (ex_flags_en),
        .ex_rd       (ex_rd),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_rd   (ex_mem_rd),
        .ex_mem_wr   (ex_mem_wr),
        .stall       (stall),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_result  (mem_result),
        .mem_rd      (mem_rd),
        .mem_wb_en   (mem_wb_en),
        .mem_mem_rd  (mem_mem_rd),
        .mem_mem_wr  (mem_mem_wr),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r,
                         input logic c, input logic [5:0] ctl,
                         input logic fe, input logic [2:0] rd,
                         input logic wb, input logic mr);
        ex_valid    = v;
        ex_result   = r;
        ex_carryout = c;
        ex_ctrl     = ctl;
        ex_flags_en = fe;
        ex_rd       = rd;
        ex_wb_en    = wb;
        ex_mem_rd   = mr;
        ex_mem_wr   = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, flag_z, flag_n, flag_c}, {29'd0, exp});
    endtask

    logic exp_fv;
    logic [2:0] exp_frd;
    logic [7:0] exp_fd;

    initial begin
        rst_n = 1'b0;
        stall = 1'($urandom);
        flush = 1'($urandom);
        drive(1'b1, 8'($urandom), 1'b1, 6'($urandom), 1'b1,
              3'($urandom), 1'b1, 1'b0);
        step();
        step();
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_result", 32'(mem_result), 32'd0);
        chk_flags("rst_flags", 3'b100);
        check("rst_fwd", 32'(fwd_valid), 32'd0);

        rst_n = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 8'h00, 1'b1, 6'b000000, 1'b1, 3'd2, 1'b1, 1'b0);
        step();
        check("arith_valid", 32'(mem_valid), 32'd1);
        check("arith_result", 32'(mem_result), 32'h00);
        check("arith_rd", 32'(mem_rd), 32'd2);
        chk_flags("arith_flags", 3'b101);

        drive(1'b1, 8'h80, 1'b0, 6'b001000, 1'b1, 3'd4, 1'b1, 1'b0);
        step();
        check("logic_result", 32'(mem_result), 32'h80);
        chk_flags("logic_flags", 3'b011);

        stall = 1'b1;
        drive(1'b1, 8'h12, 1'b0, 6'b000000, 1'b1, 3'd5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_result", 32'(mem_result), 32'h80);
            check("stall_valid", 32'(mem_valid), 32'd1);
            chk_flags("stall_flags", 3'b011);
        end

        flush = 1'b1;
        drive(1'b1, 8'h55, 1'b0, 6'b000000, 1'b1, 3'd6, 1'b1, 1'b0);
        step();
        check("flush_valid", 32'(mem_valid), 32'd0);
        check("flush_wb", 32'(mem_wb_en), 32'd0);
        check("flush_result", 32'(mem_result), 32'h80);
        chk_flags("flush_flags", 3'b011);
        check("flush_fwd", 32'(fwd_valid), 32'd0);

        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 8'hA7, 1'b0, 6'b000000, 1'b0, 3'd3, 1'b1, 1'b0);
        step();
        check("fwd_mem_result", 32'(mem_result), 32'hA7);
        chk_flags("noflag_flags", 3'b011);
`ifdef EX_MEM_FWD_EN
        exp_fv = 1'b1; exp_frd = 3'd3; exp_fd = 8'hA7;
`else
        exp_fv = 1'b0; exp_frd = 3'd0; exp_fd = 8'h00;
`endif
        check("fwd_valid", 32'(fwd_valid), 32'(exp_fv));
        check("fwd_rd", 32'(fwd_rd), 32'(exp_frd));
        check("fwd_data", 32'(fwd_data), 32'(exp_fd));

        drive(1'b1, 8'hA7, 1'b0, 6'b000000, 1'b0, 3'd3, 1'b1, 1'b1);
        step();
        check("load_memrd", 32'(mem_mem_rd), 32'd1);
        check("load_fwd", 32'(fwd_valid), 32'd0);

        drive(1'b0, 8'h33, 1'b1, 6'b000000, 1'b1, 3'd7, 1'b1, 1'b1);
        step();
        check("bubble_valid", 32'(mem_valid), 32'd0);
        check("bubble_wb", 32'(mem_wb_en), 32'd0);
        check("bubble_memrd", 32'(mem_mem_rd), 32'd0);
        check("bubble_result", 32'(mem_result), 32'hA7);
        chk_flags("bubble_flags", 3'b011);

        flush = 1'b1;
        drive(1'b1, 8'h00, 1'b0, 6'b000000, 1'b1, 3'd1, 1'b1, 1'b0);
        step();
        chk_flags("flushonly_flags", 3'b011);
        flush = 1'b0;

        drive(1'b1, 8'h7F, 1'b0, 6'b000000, 1'b1, 3'd1, 1'b0, 1'b0);
        step();
        chk_flags("clr_c_flags", 3'b000);
        check("clr_c_wb", 32'(mem_wb_en), 32'd0);

        stall = 1'b1;
        drive(1'b1, 8'h01, 1'b0, 6'b000000, 1'b1, 3'd5, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(mem_valid), 32'd0);
        check("arst_rd", 32'(mem_rd), 32'd0);
        chk_flags("arst_flags", 3'b100);
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        step();
        check("post_rst_valid", 32'(mem_valid), 32'd1);
        check("post_rst_result", 32'(mem_result), 32'h01);
        chk_flags("post_rst_flags", 3'b000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
